// File: rtl/i2s_frame_tx_pkg.sv
// Shared types and sizing helpers for the I2S frame transmitter.
package i2s_frame_tx_pkg;

  typedef enum logic [1:0] {
    StArm   = 2'd0,
    StDelay = 2'd1,
    StShift = 2'd2,
    StSkip  = 2'd3
  } tx_state_e;

  // Bit counter must reach the index of the rise that closes the frame without wrapping.
  function automatic int unsigned bit_cnt_width(input int unsigned data_w,
                                                input int unsigned channels,
                                                input int unsigned bit_delay);
    return $clog2(data_w * channels + bit_delay);
  endfunction

endpackage

// File: rtl/i2s_edge_sync.sv
// Two-flop synchroniser for one asynchronous input with registered rise/fall pulses.
module i2s_edge_sync (
  input  logic clock,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync2_q, level_q, rise_q, fall_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      level_q <= sync2_q;
      rise_q  <= sync2_q & ~level_q;
      fall_q  <= ~sync2_q & level_q;
    end
  end

  // level_q updates on the same clock the pulse appears, so both are aligned.
  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/i2s_frame_tx.sv
// Multi-channel I2S serialiser: pops words from a show-ahead FIFO and shifts them out
// MSB first, framed by oversampled BCLK/LRCLK.
module i2s_frame_tx
  import i2s_frame_tx_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned CHANNELS    = 1,
  parameter int unsigned BIT_DELAY   = 1,
  parameter logic        START_LEVEL = 1'b0
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              bclk,
  input  logic              lrclk,
  input  logic              hold,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_q,
  output logic              fifo_rdreq,
  output logic              sdata,
  output logic              busy,
  output logic              underrun,
  output logic              frame_err
);

  localparam int unsigned CntW    = bit_cnt_width(DATA_W, CHANNELS, BIT_DELAY);
  localparam int unsigned ChW     = $clog2(CHANNELS + 1);
  localparam int unsigned LastIdx = BIT_DELAY - 1 + DATA_W * CHANNELS;

  logic bclk_level, bclk_rise, bclk_fall;
  logic lr_level, lr_rise, lr_fall;
  logic unused_edges;

  i2s_edge_sync u_bclk_sync (
    .clock (clock),
    .rst_n (rst_n),
    .din   (bclk),
    .level (bclk_level),
    .rise  (bclk_rise),
    .fall  (bclk_fall)
  );

  i2s_edge_sync u_lrclk_sync (
    .clock (clock),
    .rst_n (rst_n),
    .din   (lrclk),
    .level (lr_level),
    .rise  (lr_rise),
    .fall  (lr_fall)
  );

  assign unused_edges = ^{bclk_level, lr_rise, lr_fall};

  tx_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ChW-1:0]    ch_q, ch_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              sdata_q, sdata_d;
  logic              rdreq_q, rdreq_d;
  logic              underrun_q, underrun_d;
  logic              frame_err_q, frame_err_d;
  logic              lr_prev_q, lr_prev_d;
  logic              frame_start, latch_now;

  // Channel k is latched on rise index BIT_DELAY-1 + k*DATA_W.
  function automatic logic is_latch_rise(input logic [CntW-1:0] idx, input logic [ChW-1:0] ch);
    return (32'(ch) < CHANNELS) && (32'(idx) == BIT_DELAY - 1 + 32'(ch) * DATA_W);
  endfunction

  assign frame_start = bclk_rise && (lr_level == START_LEVEL) && (lr_prev_q != START_LEVEL);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    word_d      = word_q;
    sdata_d     = sdata_q;
    rdreq_d     = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
    latch_now   = 1'b0;
    lr_prev_d   = bclk_rise ? lr_level : lr_prev_q;

    if (frame_start) begin
      // A restart abandons whatever word was in flight.
      frame_err_d = (state_q == StDelay) || (state_q == StShift);
      cnt_d       = '0;
      ch_d        = '0;
      word_d      = '0;
      sdata_d     = 1'b0;
      if (hold) begin
        state_d = StSkip;
      end else begin
        state_d   = StDelay;
        latch_now = is_latch_rise(cnt_d, ch_d);
      end
    end else if ((state_q == StDelay) || (state_q == StShift)) begin
      if (bclk_rise) begin
        cnt_d     = cnt_q + CntW'(1);
        latch_now = is_latch_rise(cnt_d, ch_q);
      end else if (bclk_fall) begin
        if (32'(cnt_q) < LastIdx) begin
          sdata_d = word_q[DATA_W-1];
          word_d  = {word_q[DATA_W-2:0], 1'b0};
        end else begin
          state_d = StArm;
          sdata_d = 1'b0;
        end
      end
    end

    if (latch_now) begin
      state_d = StShift;
      ch_d    = ch_d + ChW'(1);
      if (!fifo_empty) begin
        word_d  = fifo_q;
        rdreq_d = 1'b1;
      end else begin
        word_d     = '0;
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StArm;
      cnt_q       <= '0;
      ch_q        <= '0;
      word_q      <= '0;
      sdata_q     <= 1'b0;
      rdreq_q     <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
      lr_prev_q   <= START_LEVEL;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      word_q      <= word_d;
      sdata_q     <= sdata_d;
      rdreq_q     <= rdreq_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
      lr_prev_q   <= lr_prev_d;
    end
  end

  assign sdata      = sdata_q;
  assign fifo_rdreq = rdreq_q;
  assign underrun   = underrun_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q == StDelay) || (state_q == StShift);

endmodule

// File: tb/tb_i2s_frame_tx.sv
// Directed and randomised frames checked against a queue-based model of the frame contents.
module tb_i2s_frame_tx;

  localparam int DW = 16;
  localparam int CH = 2;
  localparam int BD = 1;
  localparam int NB = DW * CH;

  logic          clock = 1'b0;
  logic          rst_n, bclk, lrclk, hold, fifo_empty;
  logic [DW-1:0] fifo_q;
  logic          fifo_rdreq, sdata, busy, underrun, frame_err;

  always #5 clock = ~clock;

  i2s_frame_tx #(
    .DATA_W      (DW),
    .CHANNELS    (CH),
    .BIT_DELAY   (BD),
    .START_LEVEL (1'b0)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .hold       (hold),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_rdreq (fifo_rdreq),
    .sdata      (sdata),
    .busy       (busy),
    .underrun   (underrun),
    .frame_err  (frame_err)
  );

  logic [DW-1:0] dut_fifo[$];
  logic [DW-1:0] ref_fifo[$];
  int   n_pass = 0, n_fail = 0, n_checks = 0;
  int   n_rd = 0, n_ur = 0, n_fe = 0;
  logic rd_prev = 1'b0, rd_b2b = 1'b0, rd_empty = 1'b0;
  logic cap [0:63];
  logic busy_mid, busy_last;

  function automatic void drive_fifo();
    fifo_empty = (dut_fifo.size() == 0);
    fifo_q     = fifo_empty ? '0 : dut_fifo[0];
  endfunction

  task automatic push(input logic [DW-1:0] w);
    dut_fifo.push_back(w);
    ref_fifo.push_back(w);
    drive_fifo();
  endtask

  // Source FIFO and pulse counters, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (fifo_rdreq && rd_prev) rd_b2b = 1'b1;
      rd_prev = fifo_rdreq;
      if (fifo_rdreq) begin
        n_rd++;
        if (dut_fifo.size() == 0) rd_empty = 1'b1;
        else void'(dut_fifo.pop_front());
        drive_fifo();
      end
      if (underrun) n_ur++;
      if (frame_err) n_fe++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected frame: CH words taken from the FIFO in order, zero where the FIFO ran dry.
  task automatic model_frame(input logic skip, output logic [NB-1:0] exp_bits,
                             output int exp_rd, output int exp_ur);
    logic [DW-1:0] w;
    exp_bits = '0;
    exp_rd   = 0;
    exp_ur   = 0;
    if (!skip) begin
      for (int k = 0; k < CH; k++) begin
        if (ref_fifo.size() > 0) begin
          w = ref_fifo.pop_front();
          exp_rd++;
        end else begin
          w = '0;
          exp_ur++;
        end
        exp_bits = (exp_bits << DW) | NB'(w);
      end
    end
  endtask

  // One LRCLK period; cap[r] holds sdata just before BCLK rise r (r = 0 is the frame start).
  task automatic run_frame(input int low_len, input int high_len, input logic hold_init,
                           input int mid_hold_r, input int rst_r);
    n_rd = 0;
    n_ur = 0;
    n_fe = 0;
    hold = hold_init;
    for (int r = 0; r < low_len + high_len; r++) begin
      bclk  = 1'b0;
      lrclk = (r < low_len) ? 1'b0 : 1'b1;
      repeat (8) @(negedge clock);
      cap[r]    = sdata;
      busy_last = busy;
      if (r == 5) busy_mid = busy;
      if (r == mid_hold_r) hold = 1'b1;
      if (r == rst_r) begin
        rst_n = 1'b0;
        #1;
        check("reset_async", 64'({sdata, busy, fifo_rdreq, underrun, frame_err}), 64'd0);
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
      end
      bclk = 1'b1;
      repeat (8) @(negedge clock);
    end
  endtask

  task automatic check_frame(input string tag, input int period, input logic [NB-1:0] exp_bits,
                             input int exp_rd, input int exp_ur, input int exp_fe,
                             input logic exp_mid, input logic exp_end);
    logic [NB-1:0] got;
    logic          tail;
    got  = '0;
    tail = 1'b0;
    for (int j = 0; j < NB; j++) if (BD + j < period) got[NB-1-j] = cap[BD+j];
    for (int r = BD + NB; r < period; r++) tail |= cap[r];
    check({tag, "_data"}, 64'(got), 64'(exp_bits));
    check({tag, "_rdreq"}, 64'(n_rd), 64'(exp_rd));
    check({tag, "_underrun"}, 64'(n_ur), 64'(exp_ur));
    check({tag, "_frame_err"}, 64'(n_fe), 64'(exp_fe));
    check({tag, "_busy_mid"}, 64'(busy_mid), 64'(exp_mid));
    check({tag, "_busy_end"}, 64'(busy_last), 64'(exp_end));
    check({tag, "_tail_zero"}, 64'(tail), 64'd0);
  endtask

  logic [NB-1:0] eb;
  int            er, eu, nload;
  logic          skip;
  logic [DW-1:0] wa;

  initial begin
    rst_n = 1'b0;
    bclk  = 1'b0;
    lrclk = 1'b1;
    hold  = 1'b0;
    drive_fifo();
    repeat (4) @(negedge clock);
    check("reset_values", 64'({sdata, busy, fifo_rdreq, underrun, frame_err}), 64'd0);
    rst_n = 1'b1;

    repeat (3) begin
      bclk = 1'b0;
      repeat (8) @(negedge clock);
      bclk = 1'b1;
      repeat (8) @(negedge clock);
    end
    check("idle_no_pop", 64'(n_rd), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    push(16'hA5C3); push(16'h1234);
    model_frame(1'b0, eb, er, eu);
    run_frame(20, 20, 1'b0, -1, -1);
    check_frame("basic", 40, eb, er, eu, 0, 1'b1, 1'b0);

    push(16'h1234); push(16'hFFFF);
    model_frame(1'b0, eb, er, eu);
    run_frame(20, 20, 1'b0, -1, -1);
    check_frame("two_ch", 40, eb, er, eu, 0, 1'b1, 1'b0);

    push(16'h5A5A);
    model_frame(1'b0, eb, er, eu);
    run_frame(20, 20, 1'b0, -1, -1);
    check_frame("underrun", 40, eb, er, eu, 0, 1'b1, 1'b0);

    push(16'hC0DE); push(16'hBEEF);
    model_frame(1'b1, eb, er, eu);
    run_frame(20, 20, 1'b1, -1, -1);
    check_frame("skip", 40, eb, er, eu, 0, 1'b0, 1'b0);

    model_frame(1'b0, eb, er, eu);
    run_frame(20, 20, 1'b0, -1, -1);
    check_frame("after_skip", 40, eb, er, eu, 0, 1'b1, 1'b0);

    push(DW'($urandom)); push(DW'($urandom));
    model_frame(1'b0, eb, er, eu);
    run_frame(20, 20, 1'b0, 10, -1);
    check_frame("mid_hold", 40, eb, er, eu, 0, 1'b1, 1'b0);

    // Short LRCLK period: only channel 0 is latched before the next frame start.
    push(16'h9C71); push(16'h3E05);
    wa = ref_fifo.pop_front();
    run_frame(5, 5, 1'b0, -1, -1);
    check_frame("short", 10, {wa, 16'h0} & 32'hFF80_0000, 1, 0, 0, 1'b1, 1'b1);

    push(16'h6D2B);
    model_frame(1'b0, eb, er, eu);
    run_frame(20, 20, 1'b0, -1, -1);
    check_frame("restart", 40, eb, er, eu, 1, 1'b1, 1'b0);

    // Reset just before rise 10: bits 0..9 are out, everything after stays low.
    push(16'hF00D); push(16'h4B1D);
    wa = ref_fifo.pop_front();
    run_frame(20, 20, 1'b0, -1, 10);
    check_frame("reset_mid", 40, {wa, 16'h0} & 32'hFFC0_0000, 1, 0, 0, 1'b1, 1'b0);

    push(16'h0FF0);
    model_frame(1'b0, eb, er, eu);
    run_frame(20, 20, 1'b0, -1, -1);
    check_frame("post_reset", 40, eb, er, eu, 0, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      nload = int'($urandom_range(0, 3));
      for (int k = 0; k < nload; k++) push(DW'($urandom));
      skip = ($urandom_range(0, 3) == 0);
      model_frame(skip, eb, er, eu);
      run_frame(20, 20, skip, -1, -1);
      check_frame($sformatf("rand%0d", i), 40, eb, er, eu, 0, !skip, 1'b0);
    end

    check("rdreq_back_to_back", 64'(rd_b2b), 64'd0);
    check("rdreq_while_empty", 64'(rd_empty), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
